sram_burst_ctrl: RTL

//  Sequences burst accesses to the matrix operand/result SRAM (PE_COL*PE_ROW words).

---
 rtl/sram_burst_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sram_burst_ctrl.sv
// Burst sequencer for the matrix operand/result SRAM: LOAD streams words into
// consecutive addresses, DUMP reads them back one word at a time.
module sram_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_wreq,
    output logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_read_vaild,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned SUM_W = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] end_addr_c;
    logic             bad_cmd_c;
    logic             last_c;

    // Range check uses a wider sum so base+len can never wrap into a legal value.
    assign end_addr_c = SUM_W'(cmd_base) + SUM_W'(cmd_len);
    assign bad_cmd_c  = (cmd_len == '0) || (end_addr_c > SUM_W'(DEPTH));
    assign last_c     = (cnt == CNT_W'(1));

    assign cmd_ready       = (state == S_IDLE);
    assign ld_ready        = (state == S_WRITE);
    assign sram_wreq       = (state == S_WRITE) && ld_valid;
    assign sram_din        = ld_data;
    assign sram_read_vaild = (state == S_RD_ISSUE);
    assign done            = (state == S_DONE);

    // Address is held on the final beat so it never leaves base..base+len-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sram_addr <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sram_addr <= cmd_base;
                        cnt       <= cmd_len;
                        if (bad_cmd_c) begin
                            err <= 1'b1;
                        end else if (cmd_op) begin
                            state <= S_RD_ISSUE;
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (ld_valid) begin
                        cnt <= cnt - CNT_W'(1);
                        if (last_c) begin
                            state <= S_DONE;
                        end else begin
                            sram_addr <= sram_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_RD_ISSUE: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    rd_data  <= sram_dout;
                    rd_valid <= 1'b1;
                    state    <= S_RD_HOLD;
                end
                S_RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        cnt      <= cnt - CNT_W'(1);
                        if (last_c) begin
                            state <= S_DONE;
                        end else begin
                            sram_addr <= sram_addr + ADDR_WIDTH'(1);
                            state     <= S_RD_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
